// File: rtl/ff_bank_pkg.sv
// Shared types and constants for the multi-mode flip-flop bank.
package ff_bank_pkg;

    typedef enum logic [1:0] {
        MODE_SR = 2'b00,
        MODE_JK = 2'b01,
        MODE_D  = 2'b10,
        MODE_T  = 2'b11
    } mode_e;

    // Resolution of S=R=1 in SR mode
    localparam int POL_HOLD  = 0;
    localparam int POL_SET   = 1;
    localparam int POL_RESET = 2;

endpackage

// File: rtl/ff_cell.sv
// One bit of the bank: SR/JK/D/T edge-triggered flip-flop with sync reset and load.
module ff_cell
    import ff_bank_pkg::*;
#(
    parameter int SR_BOTH_POLICY = POL_HOLD
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [1:0] mode,
    input  logic       a,
    input  logic       b,
    input  logic       load,
    input  logic       load_val,
    input  logic       reset_val,
    output logic       q,
    output logic       collision
);

    logic q_q, q_d;
    logic sr_both_d;

    always_comb begin
        case (SR_BOTH_POLICY)
            POL_SET:   sr_both_d = 1'b1;
            POL_RESET: sr_both_d = 1'b0;
            default:   sr_both_d = q_q;
        endcase
    end

    always_comb begin
        q_d = q_q;
        case (mode_e'(mode))
            MODE_SR: case ({a, b})
                2'b10:   q_d = 1'b1;
                2'b01:   q_d = 1'b0;
                2'b11:   q_d = sr_both_d;
                default: q_d = q_q;
            endcase
            MODE_JK: case ({a, b})
                2'b10:   q_d = 1'b1;
                2'b01:   q_d = 1'b0;
                2'b11:   q_d = ~q_q;
                default: q_d = q_q;
            endcase
            MODE_D:  q_d = a;
            MODE_T:  q_d = q_q ^ a;
            default: q_d = q_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)       q_q <= reset_val;
        else if (load) q_q <= load_val;
        else if (en)   q_q <= q_d;
    end

    // Only a cycle that would actually apply SR inputs can collide
    assign collision = ~rst & ~load & en & (mode_e'(mode) == MODE_SR) & a & b;
    assign q         = q_q;

endmodule

// File: rtl/multimode_ff_bank.sv
// WIDTH-bit bank of run-time selectable SR/JK/D/T flip-flops with illegal-input tracking.
module multimode_ff_bank
    import ff_bank_pkg::*;
#(
    parameter int               WIDTH          = 4,
    parameter logic [WIDTH-1:0] RESET_VALUE    = '0,
    parameter int               SR_BOTH_POLICY = POL_HOLD,
    parameter int               ERR_CNT_W      = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [1:0]           mode,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 load,
    input  logic [WIDTH-1:0]     load_val,
    input  logic                 err_clr,
    output logic [WIDTH-1:0]     q,
    output logic [WIDTH-1:0]     qbar,
    output logic                 illegal,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    logic [WIDTH-1:0]     coll;
    logic                 sr_event;
    logic                 illegal_q, illegal_d;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        ff_cell #(
            .SR_BOTH_POLICY(SR_BOTH_POLICY)
        ) u_cell (
            .clk       (clk),
            .rst       (rst),
            .en        (en),
            .mode      (mode),
            .a         (a[i]),
            .b         (b[i]),
            .load      (load),
            .load_val  (load_val[i]),
            .reset_val (RESET_VALUE[i]),
            .q         (q[i]),
            .collision (coll[i])
        );
    end

    assign sr_event = |coll;

    // Clear first, then count: an event coinciding with err_clr lands at 1
    always_comb begin
        illegal_d = illegal_q;
        err_cnt_d = err_cnt_q;
        if (err_clr) begin
            illegal_d = 1'b0;
            err_cnt_d = '0;
        end
        if (sr_event) begin
            illegal_d = 1'b1;
            if (err_cnt_d != {ERR_CNT_W{1'b1}}) err_cnt_d = err_cnt_d + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            illegal_q <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            illegal_q <= illegal_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign qbar    = ~q;
    assign illegal = illegal_q;
    assign err_cnt = err_cnt_q;

endmodule

// File: doc/multimode_ff_bank.md
# multimode_ff_bank

Parametrised bank of WIDTH edge-triggered flip-flops, each bit behaving as an SR, JK, D or T flip-flop according to a run-time mode select. It is the clocked, reset-able, multi-bit successor to the single gated SR latch cell and is the storage element for the synchronous counter datapath. Compared with a gated latch, it adds:

- true edge triggering and guaranteed complementary outputs;
- synchronous parallel load;
- a configurable policy for the forbidden S=R=1 input;
- illegal-input detection with a saturating error counter.

## Interface

Parameters:
- WIDTH, 4: number of flip-flop bits.
- RESET_VALUE, 0 (WIDTH bits): q value after reset.
- SR_BOTH_POLICY, 0: SR-mode resolution of S=R=1. 0 = hold and flag; 1 = set-dominant; 2 = reset-dominant.
- ERR_CNT_W, 8: width of the illegal-event counter.

Ports:
- clk  in  1  rising-edge clock. Sole clock.
- rst  in  1  reset, synchronous and active-high.
- en  in  1  update enable for mode-driven next-state.
- mode  in  2  00 SR, 01 JK, 10 D, 11 T.
- a  in  WIDTH  S / J / D / T per bit.
- b  in  WIDTH  R / K per bit; ignored in D and T modes.
- load  in  1  synchronous parallel load.
- load_val  in  WIDTH  value loaded when load=1.
- err_clr  in  1  clears illegal and err_cnt.
- q  out  WIDTH  flip-flop state.
- qbar  out  WIDTH  always exactly ~q.
- illegal  out  1  sticky flag: S=R=1 was seen in SR mode.
- err_cnt  out  ERR_CNT_W  count of cycles with an S=R=1 event, saturating.

## Operation

- Priority on each rising clk edge is rst > load > en > hold.
- rst=1: q=RESET_VALUE, illegal=0, err_cnt=0. Reset overrides load, en and err_clr.
- load=1: q=load_val, independent of en and mode. No illegal detection occurs in a load cycle.
- en=1 and load=0: per-bit next state.
  - SR: 00 hold, 10 set, 01 clear. 11 follows SR_BOTH_POLICY: hold, set or clear.
  - JK: 00 hold, 10 set, 01 clear, 11 toggle. Never illegal.
  - D: q=a.
  - T: a=1 toggles, a=0 holds.
- en=0 and load=0: q holds. No detection occurs.
- An illegal event is a cycle with rst=0, load=0, en=1, mode=SR, and a&b nonzero for any bit. Handling:
  - All three SR_BOTH_POLICY values flag the event; the policy only changes the q outcome.
  - err_cnt increments by 1 per event cycle, regardless of how many bits collide.
  - err_cnt saturates at all-ones and never wraps.
  - illegal sets and stays set until err_clr or rst.
- err_clr=1 with no event: illegal=0, err_cnt=0 next cycle.
- err_clr=1 in the same cycle as an event: illegal=1, err_cnt=1. The new event is counted after the clear.
- Changing mode has no side effects. The new mode applies on the very edge it is sampled. No internal mode state exists.
- qbar is combinationally ~q, so q and qbar are never equal.

## Timing

- Latency is one clock for every input to q, illegal and err_cnt. There is no combinational path from the inputs to the outputs.
- All outputs are valid from the first edge with rst=1.
- Outputs before the first reset are undefined.
- Reset asserted mid-operation takes effect on that edge, discarding a concurrent load, update or err_clr.
- Saturation: at err_cnt=2^ERR_CNT_W−1, a further event leaves err_cnt unchanged and illegal=1.

## Structure

- Package ff_bank_pkg holds:
  - the mode typedef (MODE_SR, MODE_JK, MODE_D, MODE_T);
  - the policy constants (POL_HOLD, POL_SET, POL_RESET).
- Sub-module ff_cell is one bit. It takes mode, a, b, en, load, load_val, rst and RESET_VALUE bit, plus the SR_BOTH_POLICY parameter. It outputs q and a per-bit collision signal (an S=R=1 event on that bit).
- The top level instantiates WIDTH ff_cell instances via generate. It ORs the per-bit collision signals and holds the illegal/err_cnt logic.

## Test plan

- Reset and D mode: rst with RESET_VALUE=4'b1010 gives q=1010, qbar=0101, err_cnt=0. Then D mode with a=0110, en=1 gives q=0110 after 1 clk.
- JK toggle counting: q=0000, mode=JK, a=b=1111, en=1 for 3 edges gives q = 1111, 0000, 1111. illegal stays 0.
- SR policies: q=0101, mode=SR, a=b=0011.
  - POLICY=0: q=0101, illegal=1, err_cnt=1.
  - POLICY=1: q=0111.
  - POLICY=2: q=0100.
- Priority: load=1, load_val=1001, en=1, mode=T, a=1111 gives q=1001. Then rst=1 with load=1 gives q=RESET_VALUE.
- Error counter with ERR_CNT_W=2: 5 consecutive illegal cycles give err_cnt 1, 2, 3, 3, 3. Then err_clr with a simultaneous event gives err_cnt=1, illegal=1. Then err_clr alone gives 0/0.
- Hold: en=0, load=0, arbitrary a/b/mode for 4 cycles leaves q unchanged and err_cnt unchanged.
